// File: rtl/penc_pkg.sv
// Shared definitions for the sequential priority-encoder scanner.
//   penc_state_e    : scanner FSM states (IDLE, SCAN)
//   penc_mask_t     : widest mask the helper function can produce
//   penc_clear_mask : one-hot mask with only bit 'idx' set, used to clear
//                     the index that has just been handed to the consumer
package penc_pkg;

    localparam int penc_max_bits = 64;

    typedef logic [penc_max_bits-1:0] penc_mask_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } penc_state_e;

    // Callers truncate the result to their own vector width, so any width up
    // to penc_max_bits is supported.
    function automatic penc_mask_t penc_clear_mask(input int unsigned idx);
        return penc_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/penc_scanner_if.sv
// Request-in / index-out handshake bundle for penc_scanner.
//   in_val, in_rdy, in_     : request vector channel (producer -> scanner)
//   out_val, out_rdy, out   : index channel (scanner -> consumer)
//   out_last                : current index is the final one of its vector
//   out_zero                : the accepted vector was all-zero
// The slave modport is the scanner side; master is the surrounding system.
interface penc_scanner_if #(
    parameter int p_nbits = 16
);

    localparam int p_idxbits = $clog2(p_nbits);

    logic                 in_val;
    logic                 in_rdy;
    logic [p_nbits-1:0]   in_;
    logic                 out_val;
    logic                 out_rdy;
    logic [p_idxbits-1:0] out;
    logic                 out_last;
    logic                 out_zero;

    modport master (
        output in_val, in_, out_rdy,
        input  in_rdy, out_val, out, out_last, out_zero
    );

    modport slave (
        input  in_val, in_, out_rdy,
        output in_rdy, out_val, out, out_last, out_zero
    );

endinterface

// File: rtl/penc_comb.sv
// Parametrised combinational priority encoder.
//   in_      : request vector
//   out      : index of the highest-priority set bit (0 when none set)
//   out_none : no bit of in_ is set
// p_msb_first selects whether the highest or the lowest set index wins.
module penc_comb #(
    parameter int  p_nbits     = 16,
    parameter bit  p_msb_first = 1'b0,
    localparam int p_idxbits   = $clog2(p_nbits)
) (
    input  logic [p_nbits-1:0]   in_,
    output logic [p_idxbits-1:0] out,
    output logic                 out_none
);

    // Walk towards the winning end so the last hit overwrites earlier ones.
    always_comb begin
        out      = '0;
        out_none = 1'b1;
        if (p_msb_first) begin
            for (int i = 0; i < p_nbits; i++) begin
                if (in_[i]) begin
                    out      = p_idxbits'(i);
                    out_none = 1'b0;
                end
            end
        end else begin
            for (int i = p_nbits - 1; i >= 0; i--) begin
                if (in_[i]) begin
                    out      = p_idxbits'(i);
                    out_none = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/penc_scanner.sv
// Sequential priority-encoder scanner: accepts a multi-hot request vector and
// emits the index of every set bit, one per cycle, in priority order.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : penc_scanner_if slave (vector in, index/last/zero out)
// An all-zero vector yields a single transfer with out=0, out_zero=1.
// in_rdy depends combinationally on out_rdy so a new vector can be loaded in
// the same cycle as the final index of the previous one.
module penc_scanner
    import penc_pkg::*;
#(
    parameter int  p_nbits     = 16,
    parameter bit  p_msb_first = 1'b0,
    localparam int p_idxbits   = $clog2(p_nbits)
) (
    input  logic          clk,
    input  logic          reset,
    penc_scanner_if.slave bus
);

    penc_state_e          state, state_n;
    logic [p_nbits-1:0]   vec, vec_n;
    logic                 zero_flag, zero_flag_n;

    logic [p_idxbits-1:0] enc_out;
    logic                 enc_none;
    logic [p_nbits-1:0]   clr_mask;
    logic                 single;

    logic                 out_val_int;
    logic [p_idxbits-1:0] out_int;
    logic                 out_last_int;
    logic                 out_zero_int;
    logic                 in_rdy_int;

    penc_comb #(
        .p_nbits     (p_nbits),
        .p_msb_first (p_msb_first)
    ) u_enc (
        .in_      (vec),
        .out      (enc_out),
        .out_none (enc_none)
    );

    assign clr_mask = p_nbits'(penc_clear_mask(32'(enc_out)));

    // x & (x-1) removes the lowest set bit; zero result means at most one bit.
    assign single = !enc_none && ((vec & (vec - p_nbits'(1))) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vec       <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            zero_flag <= zero_flag_n;
        end
    end

    // A transfer drops the emitted bit; the final transfer either ends the
    // scan or, if a new vector is offered at the same time, reloads.
    always_comb begin
        state_n     = state;
        vec_n       = vec;
        zero_flag_n = zero_flag;
        case (state)
            IDLE: begin
                if (bus.in_val && in_rdy_int) begin
                    vec_n       = bus.in_;
                    zero_flag_n = (bus.in_ == '0);
                    state_n     = SCAN;
                end
            end
            SCAN: begin
                if (bus.out_rdy) begin
                    vec_n = vec & ~clr_mask;
                    if (out_last_int) begin
                        if (bus.in_val) begin
                            vec_n       = bus.in_;
                            zero_flag_n = (bus.in_ == '0);
                        end else begin
                            state_n     = IDLE;
                            zero_flag_n = 1'b0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs come from registered state only, apart from the in_rdy bypass.
    always_comb begin
        out_val_int  = 1'b0;
        out_int      = '0;
        out_last_int = 1'b0;
        out_zero_int = 1'b0;
        if (state == SCAN) begin
            out_val_int  = 1'b1;
            out_int      = enc_out;
            out_last_int = zero_flag || single;
            out_zero_int = zero_flag;
        end
        in_rdy_int = !reset &&
                     ((state == IDLE) || (out_last_int && bus.out_rdy));
    end

    assign bus.out_val  = out_val_int;
    assign bus.out      = out_int;
    assign bus.out_last = out_last_int;
    assign bus.out_zero = out_zero_int;
    assign bus.in_rdy   = in_rdy_int;

endmodule

// File: doc/penc_scanner.md
Name: penc_scanner

Overview:
- Parametrised sequential successor to the combinational 16-to-4 priority encoder.
- Accepts an N-bit request vector through a val/rdy input interface, then emits the index of every set bit, one per cycle, in priority order, on a val/rdy output interface.
- Used wherever a multi-hot vector must be serialised, for example pending-interrupt drain or bank wake-up.

Parameters:
- p_nbits, 16: width of the request vector; must be >= 2.
- p_msb_first, 0: 0 = lowest set index emitted first (LSB priority); 1 = highest set index emitted first.
- p_idxbits, $clog2(p_nbits): index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_val  in  1  request vector valid.
- in_rdy  out  1  block can accept a vector.
- in_  in  p_nbits  request vector.
- out_val  out  1  index valid.
- out_rdy  in  1  consumer accepts index.
- out  out  p_idxbits  index of the current highest-priority set bit.
- out_last  out  1  current index is the final one for this vector.
- out_zero  out  1  accepted vector was all-zero; out is 0.

Behaviour:
- States: IDLE and SCAN. Registers: state, vec[p_nbits-1:0], zero_flag.
- Reset (asynchronous, immediate, including mid-scan):
  - state=IDLE, vec=0, zero_flag=0.
  - out_val=0, out=0, out_last=0, out_zero=0.
  - in_rdy forced 0 while reset is high.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val&&in_rdy: vec<=in_, zero_flag<=(in_==0), state<=SCAN.
- SCAN outputs:
  - out_val=1.
  - out = priority encode of vec in the p_msb_first direction.
  - out_zero = zero_flag.
  - out_last = zero_flag OR (vec has exactly one bit set).
- SCAN transfer (out_val&&out_rdy):
  - Clear bit out of vec.
  - If out_last, the scan is done; otherwise remain in SCAN.
- Back-to-back accept:
  - in_rdy = IDLE OR (SCAN && out_last && out_rdy). This is a combinational out_rdy->in_rdy path, which is intentional.
  - If the final transfer and a new in_val coincide: load the new vector and stay in SCAN. There are no idle bubbles between vectors.
  - If the scan is done and there is no in_val: state<=IDLE.
- Latency and throughput:
  - A vector accepted in cycle t gives its first out_val in cycle t+1.
  - One index per cycle while out_rdy=1.
  - A vector with k set bits occupies k cycles; an all-zero vector occupies 1 cycle.
- Zero vector:
  - Exactly one transfer with out=0, out_zero=1, out_last=1.
  - Distinguishes an all-zero vector from bit 0 set, which the combinational encoder cannot.
- Backpressure:
  - While out_val&&!out_rdy, out, out_last and out_zero hold stable.
  - in_ is ignored while SCAN is not finishing.
- Outputs are derived combinationally from registered state only, except for the in_rdy path above.
- No X on any output after reset.

Decomposition:
- Shared package penc_pkg:
  - state enum (IDLE, SCAN).
  - a function computing the one-hot-to-clear mask from an index.
- One sub-module, penc_comb: parametrised combinational priority encoder.
  - Parameters: p_nbits, p_msb_first.
  - Ports: in_, out, out_none.
  - Instantiated once on vec.
- Everything else is in penc_scanner.

Test Plan:
1. Default params, in_=16'h8421, out_rdy=1 -> outputs 0,5,10,15 on consecutive cycles starting 1 cycle after accept; out_last=1 only on 15; in_rdy=1 in the cycle of the 15 transfer.
2. p_msb_first=1, in_=16'h8421 -> outputs 15,10,5,0; in_=16'h0000 -> single transfer out=0, out_zero=1, out_last=1.
3. Backpressure: in_=16'h0003, out_rdy low 3 cycles then high -> out holds 0 with out_last=0 for 3 cycles, then transfers 0 then 1.
4. Back-to-back: vector 16'h0010 then 16'h0100 with in_val held, out_rdy=1 -> out=4 (last, new vector accepted same cycle), next cycle out=8; no cycle with out_val=0.
5. Reset mid-scan: in_=16'hFFFF, assert reset after 3 transfers -> out_val drops immediately, in_rdy=0 during reset; after release in_rdy=1, a new 16'h0002 vector gives out=1.
6. p_nbits=5, in_=5'b10100 -> outputs 2,4 on a 3-bit out; p_nbits=32, in_=32'h8000_0000 -> out=31, out_last=1.
